// File: rtl/munoc_master_request_arbiter.sv
// Round-robin arbiter sharing one MUNOC master NI request port (AR/AW/W) among
// NUM_REQ AXI requesters, with the grant locked per transaction and an outstanding budget.
module munoc_master_request_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int BW_AR           = 32,
  parameter int BW_AW           = 32,
  parameter int BW_W            = 36,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_arvalid,
  input  logic [NUM_REQ*BW_AR-1:0]             req_archannel,
  output logic [NUM_REQ-1:0]                   req_arready,
  input  logic [NUM_REQ-1:0]                   req_awvalid,
  input  logic [NUM_REQ*BW_AW-1:0]             req_awchannel,
  output logic [NUM_REQ-1:0]                   req_awready,
  input  logic [NUM_REQ-1:0]                   req_wvalid,
  input  logic [NUM_REQ-1:0]                   req_wlast,
  input  logic [NUM_REQ*BW_W-1:0]              req_wchannel,
  output logic [NUM_REQ-1:0]                   req_wready,
  output logic                                 ni_arvalid,
  output logic [BW_AR-1:0]                     ni_archannel,
  input  logic                                 ni_arready,
  output logic                                 ni_awvalid,
  output logic [BW_AW-1:0]                     ni_awchannel,
  input  logic                                 ni_awready,
  output logic                                 ni_wvalid,
  output logic                                 ni_wlast,
  output logic [BW_W-1:0]                      ni_wchannel,
  input  logic                                 ni_wready,
  input  logic                                 rsp_done,
  output logic [$clog2(NUM_REQ)-1:0]           grant_id,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 underflow_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, RD_ADDR, WR_ADDR, WR_DATA} state_t;

  state_t                state;
  logic [GW-1:0]         rr_ptr;
  logic [GW-1:0]         winner;
  logic [GW-1:0]         scan_idx;
  logic [GW-1:0]         next_ptr;
  logic                  any_req;
  logic                  ar_done;
  logic                  aw_done;
  logic                  w_last_done;
  logic                  inc;
  logic [NUM_REQ-1:0]    requesting;
  logic [BW_AR-1:0]      ar_slice [NUM_REQ];
  logic [BW_AW-1:0]      aw_slice [NUM_REQ];
  logic [BW_W-1:0]       w_slice  [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign ar_slice[k] = req_archannel[k*BW_AR +: BW_AR];
    assign aw_slice[k] = req_awchannel[k*BW_AW +: BW_AW];
    assign w_slice[k]  = req_wchannel[k*BW_W +: BW_W];
  end

  assign requesting = req_arvalid | req_awvalid;

  // Scan from rr_ptr with wrap; the first hit wins.
  always_comb begin
    winner   = rr_ptr;
    any_req  = 1'b0;
    scan_idx = rr_ptr;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_req && requesting[scan_idx]) begin
        any_req = 1'b1;
        winner  = scan_idx;
      end
      scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
    end
  end

  always_comb begin
    req_arready  = '0;
    req_awready  = '0;
    req_wready   = '0;
    ni_arvalid   = (state == RD_ADDR) && req_arvalid[grant_id];
    ni_awvalid   = (state == WR_ADDR) && req_awvalid[grant_id];
    ni_wvalid    = (state == WR_DATA) && req_wvalid[grant_id];
    ni_wlast     = (state == WR_DATA) && req_wlast[grant_id];
    ni_archannel = ar_slice[grant_id];
    ni_awchannel = aw_slice[grant_id];
    ni_wchannel  = w_slice[grant_id];
    if (state == RD_ADDR) req_arready[grant_id] = ni_arready;
    if (state == WR_ADDR) req_awready[grant_id] = ni_awready;
    if (state == WR_DATA) req_wready[grant_id]  = ni_wready;
  end

  assign ar_done     = ni_arvalid & ni_arready;
  assign aw_done     = ni_awvalid & ni_awready;
  assign w_last_done = ni_wvalid & ni_wready & ni_wlast;
  assign inc         = ar_done | w_last_done;
  assign next_ptr    = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      outstanding   <= '0;
      underflow_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req && (outstanding < MAX_CNT)) begin
            grant_id <= winner;
            state    <= req_arvalid[winner] ? RD_ADDR : WR_ADDR;
          end
        end
        RD_ADDR: begin
          if (ar_done) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        WR_ADDR: begin
          if (aw_done) state <= WR_DATA;
        end
        WR_DATA: begin
          if (w_last_done) begin
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Simultaneous completion and new acceptance cancel out.
      if (inc && !rsp_done) begin
        outstanding <= outstanding + 1'b1;
      end else if (!inc && rsp_done) begin
        if (outstanding == '0) underflow_err <= 1'b1;
        else                   outstanding   <= outstanding - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_munoc_master_request_arbiter.sv
// Directed bench for munoc_master_request_arbiter: arbitration order, transaction
// locking, outstanding budget, underflow flag and asynchronous reset abort.
module tb_munoc_master_request_arbiter;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   arvalid, awvalid, wvalid, wlast;
  logic [NR*32-1:0] ar_pl, aw_pl;
  logic [NR*36-1:0] w_pl;
  logic            ni_arready, ni_awready, ni_wready, rsp_done;

  logic [NR-1:0]   req_arready, req_awready, req_wready;
  logic            ni_arvalid, ni_awvalid, ni_wvalid, ni_wlast;
  logic [31:0]     ni_archannel, ni_awchannel;
  logic [35:0]     ni_wchannel;
  logic [1:0]      grant_id;
  logic [3:0]      outstanding;
  logic            underflow_err;

  logic [NR-1:0]   d2_req_arready, d2_req_awready, d2_req_wready;
  logic            d2_ni_arvalid, d2_ni_awvalid, d2_ni_wvalid, d2_ni_wlast;
  logic [31:0]     d2_ni_archannel, d2_ni_awchannel;
  logic [35:0]     d2_ni_wchannel;
  logic [1:0]      d2_grant_id;
  logic [1:0]      d2_outstanding;
  logic            d2_underflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  munoc_master_request_arbiter #(.NUM_REQ(NR), .BW_AR(32), .BW_AW(32), .BW_W(36),
                                 .MAX_OUTSTANDING(8)) dut (
    .clk(clk), .rst(rst),
    .req_arvalid(arvalid), .req_archannel(ar_pl), .req_arready(req_arready),
    .req_awvalid(awvalid), .req_awchannel(aw_pl), .req_awready(req_awready),
    .req_wvalid(wvalid), .req_wlast(wlast), .req_wchannel(w_pl), .req_wready(req_wready),
    .ni_arvalid(ni_arvalid), .ni_archannel(ni_archannel), .ni_arready(ni_arready),
    .ni_awvalid(ni_awvalid), .ni_awchannel(ni_awchannel), .ni_awready(ni_awready),
    .ni_wvalid(ni_wvalid), .ni_wlast(ni_wlast), .ni_wchannel(ni_wchannel), .ni_wready(ni_wready),
    .rsp_done(rsp_done), .grant_id(grant_id), .outstanding(outstanding),
    .underflow_err(underflow_err)
  );

  munoc_master_request_arbiter #(.NUM_REQ(NR), .BW_AR(32), .BW_AW(32), .BW_W(36),
                                 .MAX_OUTSTANDING(2)) dut_small (
    .clk(clk), .rst(rst),
    .req_arvalid(arvalid), .req_archannel(ar_pl), .req_arready(d2_req_arready),
    .req_awvalid(awvalid), .req_awchannel(aw_pl), .req_awready(d2_req_awready),
    .req_wvalid(wvalid), .req_wlast(wlast), .req_wchannel(w_pl), .req_wready(d2_req_wready),
    .ni_arvalid(d2_ni_arvalid), .ni_archannel(d2_ni_archannel), .ni_arready(ni_arready),
    .ni_awvalid(d2_ni_awvalid), .ni_awchannel(d2_ni_awchannel), .ni_awready(ni_awready),
    .ni_wvalid(d2_ni_wvalid), .ni_wlast(d2_ni_wlast), .ni_wchannel(d2_ni_wchannel),
    .ni_wready(ni_wready),
    .rsp_done(rsp_done), .grant_id(d2_grant_id), .outstanding(d2_outstanding),
    .underflow_err(d2_underflow_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    arvalid = '0; awvalid = '0; wvalid = '0; wlast = '0;
    ni_arready = 1'b0; ni_awready = 1'b0; ni_wready = 1'b0; rsp_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ar_pl = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    aw_pl = {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000};
    w_pl  = {36'hC_3333_3333, 36'hC_2222_2222, 36'hC_1111_1111, 36'hC_0000_0000};

    // Reset values
    rst = 1'b1;
    clear_inputs();
    arvalid = 4'hF; awvalid = 4'hF; wvalid = 4'hF;
    ni_arready = 1'b1; ni_awready = 1'b1; ni_wready = 1'b1;
    #2;
    check("rst_arvalid", ni_arvalid, 0);
    check("rst_awvalid", ni_awvalid, 0);
    check("rst_wvalid", ni_wvalid, 0);
    check("rst_arready", req_arready, 0);
    check("rst_awready", req_awready, 0);
    check("rst_wready", req_wready, 0);
    check("rst_grant", grant_id, 0);
    check("rst_out", outstanding, 0);
    check("rst_uflow", underflow_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single AR from requester 0
    do_reset();
    arvalid = 4'b0001; ni_arready = 1'b1;
    @(negedge clk);
    check("t1_c1_arvalid", ni_arvalid, 0);
    next_cycle();
    @(negedge clk);
    check("t1_c2_arvalid", ni_arvalid, 1);
    check("t1_c2_arready", req_arready, 4'b0001);
    check("t1_c2_payload", ni_archannel, 32'hA0A0_0000);
    check("t1_c2_grant", grant_id, 0);
    check("t1_c2_out", outstanding, 0);
    next_cycle();
    arvalid = '0;
    @(negedge clk);
    check("t1_c3_out", outstanding, 1);
    check("t1_c3_arvalid", ni_arvalid, 0);

    // Four contending readers, rsp_done every cycle
    do_reset();
    arvalid = 4'hF; ni_arready = 1'b1; rsp_done = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("t2_arvalid", ni_arvalid, (c % 2 == 0));
      if (c % 2 == 0) begin
        check("t2_grant", grant_id, (c / 2 - 1) % 4);
        check("t2_arready", req_arready, 64'(1) << ((c / 2 - 1) % 4));
      end
      next_cycle();
    end
    arvalid = '0; rsp_done = 1'b0;
    @(negedge clk);
    check("t2_out", outstanding, 0);

    // Write burst from requester 2 locks out requester 1's read
    do_reset();
    arvalid = 4'b0010; awvalid = 4'b0100; wvalid = 4'b0100;
    ni_arready = 1'b1; ni_awready = 1'b1; ni_wready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      wlast = (c == 8) ? 4'b0100 : 4'b0000;
      if (c == 5) awvalid = '0;
      if (c == 9) wvalid = '0;
      @(negedge clk);
      check("t3_arready1", req_arready[1], (c == 2) || (c == 10));
      check("t3_awvalid", ni_awvalid, (c == 4));
      check("t3_wvalid", ni_wvalid, (c >= 5) && (c <= 8));
      if (c == 5) check("t3_wpayload", ni_wchannel, 36'hC_2222_2222);
      if (c == 6) check("t3_wready", req_wready, 4'b0100);
      if (c == 8) check("t3_wlast", ni_wlast, 1);
      if (c == 10) begin
        check("t3_grant", grant_id, 1);
        check("t3_out", outstanding, 2);
      end
      next_cycle();
    end
    arvalid = '0;

    // Outstanding limit of 2 holds the FSM in IDLE until a completion
    do_reset();
    arvalid = 4'b0001; ni_arready = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      rsp_done = (c == 7);
      @(negedge clk);
      if (c >= 5 && c <= 8) check("t4_blocked", d2_ni_arvalid, 0);
      if (c == 7) check("t4_out_full", d2_outstanding, 2);
      if (c == 8) check("t4_out_freed", d2_outstanding, 1);
      if (c == 9) check("t4_granted", d2_ni_arvalid, 1);
      next_cycle();
    end
    arvalid = '0; rsp_done = 1'b0;

    // Final W beat coincides with rsp_done at outstanding=3
    do_reset();
    arvalid = 4'b0001; ni_arready = 1'b1; ni_awready = 1'b1; ni_wready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 7) begin
        arvalid = '0; awvalid = 4'b0001; wvalid = 4'b0001; wlast = 4'b0001;
      end
      if (c == 9) begin
        awvalid = '0; rsp_done = 1'b1;
      end
      if (c == 10) begin
        rsp_done = 1'b0; wvalid = '0; wlast = '0;
      end
      @(negedge clk);
      if (c == 7) check("t5_out_before", outstanding, 3);
      if (c == 9) begin
        check("t5_wvalid", ni_wvalid, 1);
        check("t5_wlast", ni_wlast, 1);
      end
      if (c == 10) begin
        check("t5_out_after", outstanding, 3);
        check("t5_uflow", underflow_err, 0);
      end
      next_cycle();
    end

    // Underflow flag sets and holds
    do_reset();
    rsp_done = 1'b1;
    @(negedge clk);
    check("t6_uflow_pre", underflow_err, 0);
    next_cycle();
    rsp_done = 1'b0;
    @(negedge clk);
    check("t6_uflow_set", underflow_err, 1);
    check("t6_out_zero", outstanding, 0);
    next_cycle();
    @(negedge clk);
    check("t6_uflow_hold", underflow_err, 1);
    next_cycle();

    // Reset asserted during WR_DATA
    awvalid = 4'b1000; wvalid = 4'b1000;
    ni_awready = 1'b1; ni_wready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c < 3) next_cycle();
    end
    check("t6_wd_wvalid", ni_wvalid, 1);
    check("t6_wd_grant", grant_id, 3);
    check("t6_wd_wready", req_wready, 4'b1000);
    rst = 1'b1;
    #1;
    check("t6_rst_wvalid", ni_wvalid, 0);
    check("t6_rst_wready", req_wready, 0);
    check("t6_rst_awvalid", ni_awvalid, 0);
    check("t6_rst_grant", grant_id, 0);
    check("t6_rst_uflow", underflow_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_idle_aw", ni_awvalid, 0);
    check("t6_post_idle_w", ni_wvalid, 0);
    next_cycle();
    @(negedge clk);
    check("t6_post_waddr", ni_awvalid, 1);
    check("t6_post_no_w", ni_wvalid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
